// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_queue
//  Description : Writer side of the register-file write port. Collects
//                destination-register writes from the WB pipeline stage and
//                from the multi-cycle mul/div unit. Holds them in a small
//                in-order circular queue and drains one entry per cycle onto
//                the regfile port (RegWre / write / writeData).
//
//                Build option WBQ_BYPASS_EN:
//                  defined   - ID read addresses rs/rt are compared against
//                              every pending entry, head included. The
//                              youngest match is forwarded on
//                              byp_hitN / byp_dataN.
//                  undefined - byp_* are tied to zero and no compare logic
//                              is built.
//
//  Ports       : CLK, RST (async, active-low)
//                wb_valid/wb_addr/wb_data -> wb_stall   WB producer
//                md_valid/md_addr/md_data -> md_ready   mul/div producer
//                RegWre/write/writeData                 regfile write port
//                rs, rt -> byp_hit1/2, byp_data1/2      ID bypass lookup
//                count                                  occupied entries
//  Revision    : 1.0  initial release
// ============================================================================
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wb_valid,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_stall,
    input  logic          md_valid,
    input  logic [4:0]    md_addr,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    output logic          RegWre,
    output logic [4:0]    write,
    output logic [DW-1:0] writeData,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    output logic          byp_hit1,
    output logic [DW-1:0] byp_data1,
    output logic          byp_hit2,
    output logic [DW-1:0] byp_data2,
    output logic [AW:0]   count
);

    // Free-space arithmetic needs room for DEPTH plus one pop.
    localparam int c_FW = AW + 2;

    logic [4:0]    r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic          w_pop;
    logic [c_FW-1:0] w_free;
    logic [c_FW-1:0] w_md_need;
    logic          w_wb_req;
    logic          w_wb_take;
    logic          w_md_ok;
    logic          w_md_take;
    logic [AW-1:0] w_md_slot;

    // The head is drained every cycle the queue is non-empty. RegWre
    // depends only on registered state, so it is stable across the whole
    // cycle for the regfile's negedge sample.
    assign w_pop = (r_count != '0);

    // A pop in this cycle frees its slot for an entry arriving at the same edge.
    assign w_free    = c_FW'(DEPTH) - {1'b0, r_count} + c_FW'(w_pop);
    assign w_wb_req  = wb_valid && (wb_addr != 5'd0);
    assign w_wb_take = w_wb_req && (w_free >= c_FW'(1));

    // WB has priority. MD needs one slot beyond whatever WB takes.
    // Writes to r0 complete their handshake but are dropped.
    assign w_md_need = c_FW'(1) + c_FW'(w_wb_take);
    assign w_md_ok   = (md_addr == 5'd0) || (w_free >= w_md_need);
    assign w_md_take = md_valid && (md_addr != 5'd0) && w_md_ok;

    // With both producers enqueuing, the WB entry lands first (older).
    assign w_md_slot = r_wr_ptr + AW'(w_wb_take);

    // Handshake outputs are held low while reset is asserted.
    assign wb_stall = RST && w_wb_req && (w_free == '0);
    assign md_ready = RST && w_md_ok;

    assign RegWre    = w_pop;
    assign write     = w_pop ? r_addr[r_rd_ptr] : 5'd0;
    assign writeData = w_pop ? r_data[r_rd_ptr] : '0;
    assign count     = r_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_wb_take) begin
                r_addr[r_wr_ptr] <= wb_addr;
                r_data[r_wr_ptr] <= wb_data;
            end
            if (w_md_take) begin
                r_addr[w_md_slot] <= md_addr;
                r_data[w_md_slot] <= md_data;
            end
            r_wr_ptr <= r_wr_ptr + AW'(w_wb_take) + AW'(w_md_take);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_wb_take) + (AW+1)'(w_md_take)
                        - (AW+1)'(w_pop);
        end
    end

`ifdef WBQ_BYPASS_EN
    // Walk from oldest (rd_ptr) to youngest, so the last match seen wins.
    // Only occupied slots are considered; nothing in flight is forwarded.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < r_count) begin
                if ((rs != 5'd0) && (r_addr[r_rd_ptr + AW'(k)] == rs)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = r_data[r_rd_ptr + AW'(k)];
                end
                if ((rt != 5'd0) && (r_addr[r_rd_ptr + AW'(k)] == rt)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = r_data[r_rd_ptr + AW'(k)];
                end
            end
        end
    end
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{rs, rt};
    assign byp_hit1  = 1'b0;
    assign byp_data1 = '0;
    assign byp_hit2  = 1'b0;
    assign byp_data2 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_write_queue
//  Description : Directed self-checking bench for wb_write_queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_write_queue;

    logic        CLK;
    logic        RST;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        RegWre;
    logic [4:0]  write;
    logic [31:0] writeData;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        byp_hit1;
    logic [31:0] byp_data1;
    logic        byp_hit2;
    logic [31:0] byp_data2;
    logic [2:0]  count;

    int n_pass;
    int n_total;

    wb_write_queue #(.DEPTH(4), .AW(2), .DW(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_stall  (wb_stall),
        .md_valid  (md_valid),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .RegWre    (RegWre),
        .write     (write),
        .writeData (writeData),
        .rs        (rs),
        .rt        (rt),
        .byp_hit1  (byp_hit1),
        .byp_data1 (byp_data1),
        .byp_hit2  (byp_hit2),
        .byp_data2 (byp_data2),
        .count     (count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = '0;
        md_valid = 1'b0; md_addr = 5'd0; md_data = '0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle_inputs();
        rs = 5'd0; rt = 5'd0;
        repeat (2) @(posedge CLK);
        #1;
        n_total++;
        if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count);
        else n_pass++;
        n_total++;
        if ({RegWre, write, writeData} !== 38'd0)
            $display("FAIL reset_port: got we=%0b wa=%0d wd=%0h expected 0/0/0", RegWre, write, writeData);
        else n_pass++;
        n_total++;
        if ({wb_stall, md_ready, byp_hit1, byp_hit2} !== 4'b0000)
            $display("FAIL reset_hs: got stall=%0b ready=%0b hit1=%0b hit2=%0b expected 0000",
                     wb_stall, md_ready, byp_hit1, byp_hit2);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        wb_valid = 1; wb_addr = 5'd1; wb_data = 32'h11;
        md_valid = 1; md_addr = 5'd2; md_data = 32'h22;
        tick();
        wb_addr = 5'd3; wb_data = 32'h33;
        md_addr = 5'd4; md_data = 32'h44;
        tick();
        idle_inputs();
        n_total++;
        if (count !== 3'd3) $display("FAIL mid_count_pre: got %0d expected 3", count);
        else n_pass++;
        #2;
        RST = 1'b0;
        #1;
        n_total++;
        if (count !== 3'd0 || RegWre !== 1'b0)
            $display("FAIL mid_async: got count=%0d we=%0b expected 0/0", count, RegWre);
        else n_pass++;
        n_total++;
        if (write !== 5'd0 || writeData !== 32'd0 || md_ready !== 1'b0)
            $display("FAIL mid_port: got wa=%0d wd=%0h ready=%0b expected 0/0/0", write, writeData, md_ready);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        n_total++;
        if (RegWre !== 1'b0 || count !== 3'd0)
            $display("FAIL mid_after: got we=%0b count=%0d expected 0/0", RegWre, count);
        else n_pass++;
    endtask

    task automatic test_single_wb();
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h1234;
        #1;
        n_total++;
        if (wb_stall !== 1'b0) $display("FAIL single_stall: got %0b expected 0", wb_stall);
        else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (RegWre !== 1'b1 || write !== 5'd5 || writeData !== 32'h1234 || count !== 3'd1)
            $display("FAIL single_head: got we=%0b wa=%0d wd=%0h cnt=%0d expected 1/5/1234/1",
                     RegWre, write, writeData, count);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 3'd0 || RegWre !== 1'b0)
            $display("FAIL single_empty: got cnt=%0d we=%0b expected 0/0", count, RegWre);
        else n_pass++;
    endtask

    task automatic test_dual_order();
        wb_valid = 1; wb_addr = 5'd3; wb_data = 32'hA;
        md_valid = 1; md_addr = 5'd4; md_data = 32'hB;
        #1;
        n_total++;
        if (md_ready !== 1'b1) $display("FAIL dual_ready: got %0b expected 1", md_ready);
        else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (write !== 5'd3 || writeData !== 32'hA || count !== 3'd2)
            $display("FAIL dual_first: got wa=%0d wd=%0h cnt=%0d expected 3/a/2", write, writeData, count);
        else n_pass++;
        tick();
        n_total++;
        if (write !== 5'd4 || writeData !== 32'hB || count !== 3'd1)
            $display("FAIL dual_second: got wa=%0d wd=%0h cnt=%0d expected 4/b/1", write, writeData, count);
        else n_pass++;
        tick();
        n_total++;
        if (RegWre !== 1'b0) $display("FAIL dual_empty: got we=%0b expected 0", RegWre);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [2:0] exp_cnt [4];
        exp_cnt[0] = 3'd2; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd4; exp_cnt[3] = 3'd4;
        // Three cycles of wb+md with the drain running brings the queue to 4.
        for (int c = 0; c < 3; c++) begin
            wb_valid = 1; wb_addr = 5'(2*c + 1); wb_data = 32'h100 + 32'(2*c + 1);
            md_valid = 1; md_addr = 5'(2*c + 2); md_data = 32'h100 + 32'(2*c + 2);
            #1;
            n_total++;
            if (md_ready !== 1'b1) $display("FAIL fill_ready%0d: got %0b expected 1", c, md_ready);
            else n_pass++;
            tick();
            n_total++;
            if (count !== exp_cnt[c]) $display("FAIL fill_cnt%0d: got %0d expected %0d", c, count, exp_cnt[c]);
            else n_pass++;
        end
        wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h107;
        md_valid = 1; md_addr = 5'd8; md_data = 32'h108;
        #1;
        n_total++;
        if (md_ready !== 1'b0 || wb_stall !== 1'b0 || count !== 3'd4)
            $display("FAIL full_hs: got ready=%0b stall=%0b cnt=%0d expected 0/0/4", md_ready, wb_stall, count);
        else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (count !== 3'd4) $display("FAIL full_cnt: got %0d expected 4", count);
        else n_pass++;
        // Remaining drain order: r4, r5, r6, r7 (r8 was never accepted).
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (write !== 5'(4 + k) || writeData !== 32'h104 + 32'(k) || count !== 3'(4 - k))
                $display("FAIL drain%0d: got wa=%0d wd=%0h cnt=%0d expected %0d/%0h/%0d",
                         k, write, writeData, count, 4 + k, 32'h104 + 32'(k), 4 - k);
            else n_pass++;
            tick();
        end
        n_total++;
        if (count !== 3'd0 || RegWre !== 1'b0)
            $display("FAIL drain_end: got cnt=%0d we=%0b expected 0/0", count, RegWre);
        else n_pass++;
    endtask

    task automatic test_r0();
        wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        md_valid = 1; md_addr = 5'd0; md_data = 32'hBEEF;
        #1;
        n_total++;
        if (wb_stall !== 1'b0 || md_ready !== 1'b1)
            $display("FAIL r0_hs: got stall=%0b ready=%0b expected 0/1", wb_stall, md_ready);
        else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (count !== 3'd0 || RegWre !== 1'b0)
            $display("FAIL r0_drop: got cnt=%0d we=%0b expected 0/0", count, RegWre);
        else n_pass++;
    endtask

    task automatic test_bypass();
        wb_valid = 1; wb_addr = 5'd7; wb_data = 32'd1;
        md_valid = 1; md_addr = 5'd7; md_data = 32'd2;
        tick();
        idle_inputs();
        rs = 5'd7; rt = 5'd9;
        #1;
`ifdef WBQ_BYPASS_EN
        n_total++;
        if (byp_hit1 !== 1'b1 || byp_data1 !== 32'd2 || byp_hit2 !== 1'b0)
            $display("FAIL byp_young: got hit1=%0b d1=%0h hit2=%0b expected 1/2/0", byp_hit1, byp_data1, byp_hit2);
        else n_pass++;
        rs = 5'd0; rt = 5'd7;
        #1;
        n_total++;
        if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b1 || byp_data2 !== 32'd2)
            $display("FAIL byp_r0: got hit1=%0b hit2=%0b d2=%0h expected 0/1/2", byp_hit1, byp_hit2, byp_data2);
        else n_pass++;
        rs = 5'd7;
        tick();
        n_total++;
        if (byp_hit1 !== 1'b1 || byp_data1 !== 32'd2 || count !== 3'd1)
            $display("FAIL byp_head: got hit1=%0b d1=%0h cnt=%0d expected 1/2/1", byp_hit1, byp_data1, count);
        else n_pass++;
        tick();
        n_total++;
        if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0)
            $display("FAIL byp_empty: got hit1=%0b hit2=%0b expected 0/0", byp_hit1, byp_hit2);
        else n_pass++;
`else
        rt = 5'd7;
        #1;
        n_total++;
        if ({byp_hit1, byp_data1, byp_hit2, byp_data2} !== 66'd0)
            $display("FAIL byp_off: got hit1=%0b d1=%0h hit2=%0b d2=%0h expected all 0",
                     byp_hit1, byp_data1, byp_hit2, byp_data2);
        else n_pass++;
        repeat (2) tick();
`endif
        rs = 5'd0; rt = 5'd0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_reset_mid_drain();
        test_single_wb();
        test_dual_order();
        test_full();
        test_r0();
        test_bypass();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
